// File: rtl/therm_pkg.sv
// Shared types and helpers for the thermometer time decoder.
package therm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Largest arrival time representable in cnt_w bits; also the last sample of a window.
  function automatic int unsigned max_t(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  // Low bit of a lane's slice in the packed time word.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned cnt_w);
    return lane * cnt_w;
  endfunction

endpackage

// File: rtl/therm_lane_capture.sv
// Per-lane first-edge timestamp, hit flag and sticky non-monotone error flag.
module therm_lane_capture
  import therm_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] count,
  input  logic             lane_in,
  input  logic             force_timeout,
  output logic [CNT_W-1:0] arr_time,
  output logic             hit,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_t(CNT_W));

  // Capture first rise; lanes still unhit at window close report the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_time <= '0;
      hit      <= 1'b0;
      err      <= 1'b0;
    end else if (clear) begin
      arr_time <= '0;
      hit      <= 1'b0;
      err      <= 1'b0;
    end else if (sample_en) begin
      if (!hit && lane_in) begin
        arr_time <= count;
        hit      <= 1'b1;
      end else if (!hit && force_timeout) begin
        arr_time <= MAX_CNT;
      end
      if (hit && !lane_in) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/therm_time_decoder.sv
// Race-logic readout: timestamps first rising edge per lane within a window, valid/ready result.
module therm_time_decoder
  import therm_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LANES-1:0]       lane_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*CNT_W-1:0] out_time,
  output logic [LANES-1:0]       out_hit,
  output logic [LANES-1:0]       out_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_t(CNT_W));

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             clear_c;
  logic             sample_en_c;
  logic             done_c;
  logic             all_hit_c;

  // Window closes early once every lane has risen, counting the current sample.
  assign all_hit_c = &(out_hit | lane_in);

  // State, sample counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      busy      <= (state_nx != IDLE);
      out_valid <= (state_nx == HOLD);
    end
  end

  // Next-state, counter and lane-control decode.
  always_comb begin
    state_nx    = state;
    count_nx    = count;
    clear_c     = 1'b0;
    sample_en_c = 1'b0;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        clear_c  = 1'b1;
        count_nx = '0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        sample_en_c = 1'b1;
        count_nx    = count + CNT_W'(1);
        if (all_hit_c || (count == MAX_CNT)) begin
          done_c   = 1'b1;
          state_nx = HOLD;
          count_nx = '0;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One capture slice per lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    therm_lane_capture #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear_c),
      .sample_en    (sample_en_c),
      .count        (count),
      .lane_in      (lane_in[i]),
      .force_timeout(done_c),
      .arr_time     (out_time[lane_lo(i, CNT_W) +: CNT_W]),
      .hit          (out_hit[i]),
      .err          (out_err[i])
    );
  end

endmodule
